// File: rtl/btn_conditioner.sv
// btn_conditioner
//   Multi-channel push-button front end: 2-FF synchroniser, counter debounce
//   clocked by a sample_en strobe, and registered one-clk rise/fall pulses.
//   Each channel is an independent btn_conditioner_lane instance.
//
//   Optional feature macro: BTN_AUTOREPEAT_EN
//     defined   -> btn_rep pulses on press, after REP_DLY held ticks, then
//                  every REP_RATE ticks while the button stays down.
//     undefined -> btn_rep is tied to 0 and no repeat logic is built.
//
// Ports
//   clk        in   1   system clock, all state on posedge
//   rst_n      in   1   synchronous active-low reset
//   sample_en  in   1   debounce sampling strobe (tie 1 to sample every clk)
//   btn_raw    in   CH  asynchronous raw buttons, active-high
//   btn_lvl    out  CH  debounced level
//   btn_rise   out  CH  1-clk pulse on the first cycle btn_lvl is 1
//   btn_fall   out  CH  1-clk pulse on the first cycle btn_lvl is 0
//   btn_rep    out  CH  1-clk press / auto-repeat pulse

module btn_conditioner_lane #(
    parameter int DB_CNT   = 4,
    parameter int REP_DLY  = 32,
    parameter int REP_RATE = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_en,
    input  logic raw,
    output logic lvl,
    output logic rise,
    output logic fall,
    output logic rep
);
    localparam int CW = $clog2(DB_CNT + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          flip;

    // Last differing sample of a run: btn_lvl takes the synchronised value.
    assign flip = sample_en && (sync2 != lvl) && (cnt == CW'(DB_CNT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            lvl   <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // Edge pulses only look at flip, so they last one clk no matter
            // how sparse sample_en is.
            rise  <= flip && sync2;
            fall  <= flip && !sync2;
            if (sample_en) begin
                if (sync2 == lvl) begin
                    cnt <= '0;
                end else if (flip) begin
                    lvl <= sync2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RMAX = (REP_DLY > REP_RATE) ? REP_DLY : REP_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rcnt;
    logic [RW-1:0] rcnt_inc;
    logic          rphase;   // 0: waiting out REP_DLY, 1: repeating at REP_RATE
    logic          rep_hit;

    assign rcnt_inc = rcnt + RW'(1);
    assign rep_hit  = rphase ? (rcnt_inc == RW'(REP_RATE))
                             : (rcnt_inc == RW'(REP_DLY));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rcnt   <= '0;
            rphase <= 1'b0;
            rep    <= 1'b0;
        end else begin
            rep <= 1'b0;
            if (!lvl) begin
                // Released: stay cleared; the press tick itself is tick 0.
                rcnt   <= '0;
                rphase <= 1'b0;
                rep    <= flip && sync2;
            end else if (sample_en && !flip) begin
                // A tick that releases the button never emits a repeat.
                if (rep_hit) begin
                    rep    <= 1'b1;
                    rcnt   <= '0;
                    rphase <= 1'b1;
                end else begin
                    rcnt <= rcnt_inc;
                end
            end
        end
    end
`else
    assign rep = 1'b0;
`endif

endmodule

module btn_conditioner #(
    parameter int CH       = 2,
    parameter int DB_CNT   = 4,
    parameter int REP_DLY  = 32,
    parameter int REP_RATE = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sample_en,
    input  logic [CH-1:0] btn_raw,
    output logic [CH-1:0] btn_lvl,
    output logic [CH-1:0] btn_rise,
    output logic [CH-1:0] btn_fall,
    output logic [CH-1:0] btn_rep
);
    if (CH < 1 || DB_CNT < 1 || REP_DLY < 1 || REP_RATE < 1) begin : g_bad_param
        $error("btn_conditioner: CH, DB_CNT, REP_DLY and REP_RATE must be >= 1");
    end

    for (genvar i = 0; i < CH; i++) begin : g_lane
        btn_conditioner_lane #(
            .DB_CNT  (DB_CNT),
            .REP_DLY (REP_DLY),
            .REP_RATE(REP_RATE)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .sample_en(sample_en),
            .raw      (btn_raw[i]),
            .lvl      (btn_lvl[i]),
            .rise     (btn_rise[i]),
            .fall     (btn_fall[i]),
            .rep      (btn_rep[i])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner (CH=2, DB_CNT=4, REP_DLY=32, REP_RATE=8).
// Inputs change 1 time unit after each rising edge; outputs are checked there.
// Expected btn_rep follows BTN_AUTOREPEAT_EN when it is defined for the build.

module tb_btn_conditioner;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       sample_en;
    logic [1:0] btn_raw;
    logic [1:0] btn_lvl, btn_rise, btn_fall, btn_rep;

`ifdef BTN_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    int  n_cmp = 0;
    int  n_err = 0;
    bit  div4  = 1'b0;
    int  ph    = 0;

    btn_conditioner #(.CH(2), .DB_CNT(4), .REP_DLY(32), .REP_RATE(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sample_en(sample_en),
        .btn_raw  (btn_raw),
        .btn_lvl  (btn_lvl),
        .btn_rise (btn_rise),
        .btn_fall (btn_fall),
        .btn_rep  (btn_rep)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [1:0] lvl, input logic [1:0] rise,
                        input logic [1:0] fall, input logic [1:0] rep);
        chk({tag, ".lvl"},  32'(btn_lvl),  32'(lvl));
        chk({tag, ".rise"}, 32'(btn_rise), 32'(rise));
        chk({tag, ".fall"}, 32'(btn_fall), 32'(fall));
        chk({tag, ".rep"},  32'(btn_rep),  32'(rep));
    endtask

    // One clock; in div4 mode sample_en is high on every 4th edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (div4) begin
            ph        = (ph + 1) % 4;
            sample_en = (ph == 3);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        sample_en = 1'b1;
        btn_raw   = 2'b11;

        // Reset held with buttons pressed: everything stays 0.
        for (int k = 1; k <= 3; k++) begin
            step();
            chk4("reset", 2'b00, 2'b00, 2'b00, 2'b00);
        end

        // Held through reset release, both rise on the same edge (6th).
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk4("both_press", (k >= 6) ? 2'b11 : 2'b00, (k == 6) ? 2'b11 : 2'b00,
                 2'b00, (AR && k == 6) ? 2'b11 : 2'b00);
        end

        // Release ch0 only.
        btn_raw = 2'b10;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk4("rel_ch0", (k >= 6) ? 2'b10 : 2'b11, 2'b00,
                 (k == 6) ? 2'b01 : 2'b00, 2'b00);
        end

        btn_raw = 2'b00;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk4("rel_ch1", (k >= 6) ? 2'b00 : 2'b10, 2'b00,
                 (k == 6) ? 2'b10 : 2'b00, 2'b00);
        end

        // Single press on ch0, sample every clk.
        btn_raw = 2'b01;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk4("press_ch0", (k >= 6) ? 2'b01 : 2'b00, (k == 6) ? 2'b01 : 2'b00,
                 2'b00, (AR && k == 6) ? 2'b01 : 2'b00);
        end
        btn_raw = 2'b00;
        for (int k = 1; k <= 8; k++) step();
        chk4("idle0", 2'b00, 2'b00, 2'b00, 2'b00);

        // Glitch of 3 samples is rejected.
        for (int k = 1; k <= 12; k++) begin
            btn_raw = (k <= 3) ? 2'b01 : 2'b00;
            step();
            chk4("glitch", 2'b00, 2'b00, 2'b00, 2'b00);
        end

        // sample_en every 4th clk: rise lands on edge 16.
        btn_raw   = 2'b10;
        div4      = 1'b1;
        ph        = 0;
        sample_en = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            step();
            chk4("slow_se", (k >= 16) ? 2'b10 : 2'b00, (k == 16) ? 2'b10 : 2'b00,
                 2'b00, (AR && k == 16) ? 2'b10 : 2'b00);
        end
        div4      = 1'b0;
        sample_en = 1'b1;
        btn_raw   = 2'b00;
        for (int k = 1; k <= 8; k++) step();
        chk4("idle1", 2'b00, 2'b00, 2'b00, 2'b00);

        // Reset while ch0 is high and a release count is in progress.
        btn_raw = 2'b01;
        for (int k = 1; k <= 6; k++) step();
        chk("pre_rst.lvl", 32'(btn_lvl), 32'd1);
        btn_raw = 2'b00;
        for (int k = 1; k <= 3; k++) step();
        rst_n = 1'b0;
        step();
        chk4("mid_rst", 2'b00, 2'b00, 2'b00, 2'b00);
        rst_n   = 1'b1;
        btn_raw = 2'b01;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk4("post_rst", (k == 6) ? 2'b01 : 2'b00, (k == 6) ? 2'b01 : 2'b00,
                 2'b00, (AR && k == 6) ? 2'b01 : 2'b00);
        end

        // Hold ch0: press was tick 0; repeats at 32, 40, ..., 96.
        for (int k = 1; k <= 98; k++) begin
            step();
            chk4("hold", 2'b01, 2'b00, 2'b00,
                 (AR && (k == 32 || (k > 32 && (k - 32) % 8 == 0))) ? 2'b01 : 2'b00);
        end

        // Release lands on tick 104, a repeat slot: no pulse may appear.
        btn_raw = 2'b00;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk4("hold_rel", (k >= 6) ? 2'b00 : 2'b01, 2'b00,
                 (k == 6) ? 2'b01 : 2'b00, 2'b00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
